// File: rtl/ram2_arbiter.sv
// Round-robin arbiter sharing one ram2 port between two valid/ready clients.
// Writes take one RAM cycle and reads take two; each completion is a one-cycle rsp pulse.
module ram2_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD1  = 2'd2;
  localparam logic [1:0] S_RD2  = 2'd3;

  logic [1:0]        r_state;
  logic              r_last;
  logic              r_we;
  logic              r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp0_rdata;
  logic [DATA_W-1:0] r_rsp1_rdata;

  logic              w_idle;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_accept;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // On a tie the client that was not served last wins.
  assign w_idle      = (r_state == S_IDLE);
  assign w_grant0    = w_idle & req0_valid & (~req1_valid | r_last);
  assign w_grant1    = w_idle & req1_valid & (~req0_valid | ~r_last);
  assign w_accept    = w_grant0 | w_grant1;
  assign w_sel_we    = w_grant1 ? req1_we    : req0_we;
  assign w_sel_addr  = w_grant1 ? req1_addr  : req0_addr;
  assign w_sel_wdata = w_grant1 ? req1_wdata : req0_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last       <= 1'b1;
      r_we         <= 1'b0;
      r_id         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id    <= w_grant1;
            r_last  <= w_grant1;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_state <= w_sel_we ? S_WR : S_RD1;
          end
        end
        S_WR: begin
          r_state      <= S_IDLE;
          r_rsp0_valid <= ~r_id;
          r_rsp1_valid <= r_id;
        end
        S_RD1: begin
          r_state <= S_RD2;
        end
        default: begin
          // Second read cycle: data is valid for both combinational and registered RAMs.
          r_state      <= S_IDLE;
          r_rsp0_valid <= ~r_id;
          r_rsp1_valid <= r_id;
          if (r_id) r_rsp1_rdata <= ram_data;
          else      r_rsp0_rdata <= ram_data;
        end
      endcase
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp1_rdata = r_rsp1_rdata;
  assign busy       = ~w_idle;
  assign ram_ena    = ~w_idle;
  assign ram_wena   = (r_state == S_WR);
  assign ram_addr   = w_idle ? '0 : r_addr;
  assign ram_data   = (r_state == S_WR) ? r_wdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram2_arbiter.sv
// Bench for ram2_arbiter: a ram2 model on the shared bus, a latency-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_ram2_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [31:0] PARK = 32'h5A5A_C3C3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0Valid, req0We, req0Ready, rsp0Valid;
  logic [AW-1:0] req0Addr;
  logic [DW-1:0] req0Wdata, rsp0Rdata;
  logic          req1Valid, req1We, req1Ready, rsp1Valid;
  logic [AW-1:0] req1Addr;
  logic [DW-1:0] req1Wdata, rsp1Rdata;
  logic          ramEna, ramWena, busy;
  logic [AW-1:0] ramAddr;
  wire  [DW-1:0] ramData;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  ram2_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0Valid), .req0_we(req0We), .req0_addr(req0Addr), .req0_wdata(req0Wdata),
    .req0_ready(req0Ready), .rsp0_valid(rsp0Valid), .rsp0_rdata(rsp0Rdata),
    .req1_valid(req1Valid), .req1_we(req1We), .req1_addr(req1Addr), .req1_wdata(req1Wdata),
    .req1_ready(req1Ready), .rsp1_valid(rsp1Valid), .rsp1_rdata(rsp1Rdata),
    .ram_ena(ramEna), .ram_wena(ramWena), .ram_addr(ramAddr), .ram_data(ramData),
    .busy(busy)
  );

  // ram2 model: combinational read drive, write on the clock edge; a parked pattern
  // stands in for the released bus so any stray DUT drive shows up as a wrong value.
  logic [DW-1:0] ramMem [32];
  initial for (int i = 0; i < 32; i++) ramMem[i] = '0;
  always @(posedge clk) if (ramEna && ramWena) ramMem[ramAddr] <= ramData;
  assign ramData = !ramEna ? PARK : (!ramWena ? ramMem[ramAddr] : {DW{1'bz}});

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference model: an accepted op occupies the port for 1 (write) or 2 (read) cycles,
  // then completes with a response in the next cycle.
  int            mRemain;
  logic          mLast, mWe, mId;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata;
  logic          mRspV [2];
  logic [DW-1:0] mRdata [2];
  logic [DW-1:0] mMem [32];

  initial begin
    logic expReady0, expReady1;
    logic [DW-1:0] expData;
    logic nextRspV [2];
    for (int i = 0; i < 32; i++) mMem[i] = '0;
    mRemain = 0; mLast = 1'b1; mWe = 1'b0; mId = 1'b0; mAddr = '0; mWdata = '0;
    mRspV[0] = 1'b0; mRspV[1] = 1'b0; mRdata[0] = '0; mRdata[1] = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      expReady0 = (mRemain == 0) && req0Valid && (!req1Valid || mLast);
      expReady1 = (mRemain == 0) && req1Valid && (!req0Valid || !mLast);
      expData   = (mRemain == 0) ? PARK : (mWe ? mWdata : mMem[mAddr]);
      checkOutput("req0_ready", req0Ready, expReady0);
      checkOutput("req1_ready", req1Ready, expReady1);
      checkOutput("busy", busy, mRemain != 0);
      checkOutput("ram_ena", ramEna, mRemain != 0);
      checkOutput("ram_wena", ramWena, (mRemain != 0) && mWe);
      checkOutput("ram_addr", ramAddr, (mRemain != 0) ? mAddr : 5'd0);
      checkOutput("ram_data", ramData, expData);
      checkOutput("rsp0_valid", rsp0Valid, mRspV[0]);
      checkOutput("rsp1_valid", rsp1Valid, mRspV[1]);
      checkOutput("rsp0_rdata", rsp0Rdata, mRdata[0]);
      checkOutput("rsp1_rdata", rsp1Rdata, mRdata[1]);
      nextRspV[0] = 1'b0;
      nextRspV[1] = 1'b0;
      if (rst) begin
        if (mRemain != 0 && mWe) mMem[mAddr] = mWdata;
        mRemain = 0; mLast = 1'b1; mRdata[0] = '0; mRdata[1] = '0;
      end else if (mRemain != 0) begin
        mRemain--;
        if (mRemain == 0) begin
          nextRspV[mId] = 1'b1;
          if (mWe) mMem[mAddr] = mWdata;
          else     mRdata[mId] = mMem[mAddr];
        end
      end else if (expReady0 || expReady1) begin
        mId     = expReady1;
        mLast   = expReady1;
        mWe     = expReady1 ? req1We : req0We;
        mAddr   = expReady1 ? req1Addr : req0Addr;
        mWdata  = expReady1 ? req1Wdata : req0Wdata;
        mRemain = mWe ? 1 : 2;
      end
      mRspV[0] = nextRspV[0];
      mRspV[1] = nextRspV[1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int id, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (id == 0) begin
      req0Valid = 1'b1; req0We = we; req0Addr = addr; req0Wdata = data;
    end else begin
      req1Valid = 1'b1; req1We = we; req1Addr = addr; req1Wdata = data;
    end
  endtask

  task automatic clearClient(input int id);
    if (id == 0) req0Valid = 1'b0;
    else         req1Valid = 1'b0;
  endtask

  // Returns in the cycle after acceptance; acceptCycle is the cycle of acceptance.
  task automatic waitGrant(input int id, output int acceptCycle);
    bit seen = 0;
    acceptCycle = -1;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if ((id == 0 && req0Ready) || (id == 1 && req1Ready)) begin
        seen = 1;
        acceptCycle = cycle;
      end
      tick();
    end
    if (!seen) begin
      errors++;
      $display("[TB] FAIL grant_timeout: client %0d never got ready, required within 20 cycles", id);
    end
  endtask

  task automatic doOp(input int id, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int acc;
    applyStimulus(id, we, addr, data);
    waitGrant(id, acc);
    clearClient(id);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int acc [4];
    int grants [4];
    int bothSeen;
    rst = 1'b1;
    req0Valid = 0; req0We = 0; req0Addr = '0; req0Wdata = '0;
    req1Valid = 0; req1We = 0; req1Addr = '0; req1Wdata = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("lit_reset_busy", busy, 1'b0);
    checkOutput("lit_reset_rdata0", rsp0Rdata, 32'h0);
    checkOutput("lit_reset_bus", ramData, PARK);

    // Reset held two cycles during a write.
    doOp(0, 1'b1, 5'd3, 32'hA5A5A5A5);
    checkOutput("lit_midwr_wena", ramWena, 1'b1);
    pulseReset();
    checkOutput("lit_after_reset_busy", busy, 1'b0);
    checkOutput("lit_after_reset_rsp0", rsp0Valid, 1'b0);
    checkOutput("lit_after_reset_ena", ramEna, 1'b0);
    checkOutput("lit_after_reset_bus", ramData, PARK);

    // Single write then read on client 0.
    doOp(0, 1'b1, 5'd0, 32'hFFFFFFFF);
    checkOutput("lit_wr_ena", ramEna, 1'b1);
    checkOutput("lit_wr_wena", ramWena, 1'b1);
    tick();
    checkOutput("lit_wr_rsp0", rsp0Valid, 1'b1);
    checkOutput("lit_wr_idle_ena", ramEna, 1'b0);
    doOp(0, 1'b0, 5'd0, 32'h0);
    checkOutput("lit_rd1_wena", ramWena, 1'b0);
    tick();
    checkOutput("lit_rd2_ena", ramEna, 1'b1);
    tick();
    checkOutput("lit_rd_rsp0", rsp0Valid, 1'b1);
    checkOutput("lit_rd_rdata0", rsp0Rdata, 32'hFFFFFFFF);

    // Tie round-robin after a fresh reset.
    pulseReset();
    applyStimulus(0, 1'b1, 5'd4, 32'hFF00FF00);
    applyStimulus(1, 1'b1, 5'd5, 32'hFFF0FFF0);
    for (int k = 0; k < 4; k++) begin
      bothSeen = 0;
      grants[k] = -1;
      for (int n = 0; n < 20 && !bothSeen; n++) begin
        @(negedge clk);
        if (req0Ready || req1Ready) begin
          bothSeen = 1;
          grants[k] = req1Ready ? 1 : 0;
        end
        tick();
      end
    end
    clearClient(0);
    clearClient(1);
    checkOutput("lit_tie_grant0", grants[0], 0);
    checkOutput("lit_tie_grant1", grants[1], 1);
    checkOutput("lit_tie_grant2", grants[2], 0);
    checkOutput("lit_tie_grant3", grants[3], 1);
    tick();
    doOp(0, 1'b0, 5'd4, 32'h0);
    tick();
    tick();
    checkOutput("lit_tie_rdata0", rsp0Rdata, 32'hFF00FF00);
    checkOutput("lit_tie_rsp1_quiet", rsp1Valid, 1'b0);
    doOp(1, 1'b0, 5'd5, 32'h0);
    tick();
    tick();
    checkOutput("lit_tie_rdata1", rsp1Rdata, 32'hFFF0FFF0);
    checkOutput("lit_tie_rdata0_held", rsp0Rdata, 32'hFF00FF00);

    // Continuous reads from client 1 are accepted every third cycle.
    applyStimulus(1, 1'b0, 5'd5, 32'h0);
    for (int k = 0; k < 4; k++) waitGrant(1, acc[k]);
    clearClient(1);
    for (int k = 1; k < 4; k++) checkOutput("lit_b2b_spacing", acc[k] - acc[k-1], 3);
    tick();
    tick();

    // Inputs churn while a write is in flight.
    applyStimulus(0, 1'b1, 5'd7, 32'h12345678);
    waitGrant(0, acc[0]);
    req0Addr = 5'd8;
    req0Wdata = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("lit_churn_ready", req0Ready, 1'b0);
    checkOutput("lit_churn_addr", ramAddr, 5'd7);
    tick();
    clearClient(0);
    tick();
    doOp(0, 1'b0, 5'd7, 32'h0);
    tick();
    tick();
    checkOutput("lit_churn_rdata", rsp0Rdata, 32'h12345678);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at 100000 time units, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
